// File: rtl/fetch_prefetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory port.
interface fetch_prefetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            instr_req_out;
  logic [XLEN-1:0] instr_addr_out;
  logic            gnt_in;
  logic            instr_rvalid_in;
  logic [XLEN-1:0] instr_rdata_in;

  modport master (
    output instr_req_out, instr_addr_out,
    input  gnt_in, instr_rvalid_in, instr_rdata_in
  );

  modport slave (
    input  instr_req_out, instr_addr_out,
    output gnt_in, instr_rvalid_in, instr_rdata_in
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: pipelined req/gnt instruction fetch with credit-limited issue, a PC queue
// for in-flight requests and a show-ahead prefetch FIFO; mispredicts flush and redirect.
module fetch_prefetch_buffer #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                    req,
  input  logic                    reset,
  fetch_prefetch_buffer_if.master mem,
  input  logic                    branch_mispredicted_in,
  input  logic [XLEN-1:0]         branch_target_in,
  input  logic                    stall_in,
  output logic                    valid_out,
  output logic [XLEN-1:0]         instr_out,
  output logic [XLEN-1:0]         pc_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   outstanding_q, outstanding_d, discard_q, occ_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, pcq_rd_q, pcq_wr_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pcq_mem   [DEPTH];
  logic [CW:0]     inflight;
  logic            credit, fetch_req, xfer, resp, drop, push, pop, flush;

  // Slots already claimed by buffered data plus responses that will still be kept.
  assign inflight = {1'b0, occ_q} + {1'b0, outstanding_q} - {1'b0, discard_q};
  assign credit   = (outstanding_q < MAX_OUT_C) && (inflight < DEPTH_C);

  assign flush = branch_mispredicted_in;
  assign xfer  = fetch_req && mem.gnt_in;
  assign resp  = mem.instr_rvalid_in && (outstanding_q != '0);
  assign drop  = resp && (discard_q != '0);
  assign push  = resp && !drop && !flush;
  assign pop   = valid_out && !stall_in;

  assign mem.instr_req_out  = fetch_req;
  assign mem.instr_addr_out = addr_q;
  assign valid_out          = (occ_q != '0);
  assign instr_out          = instr_mem[rd_ptr_q];
  assign pc_out             = pc_mem[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        fetch_req = credit;
        if (!credit) state_d = FULL;
      end
      FULL: begin
        fetch_req = credit;
        if (credit) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (xfer && !resp)      outstanding_d = outstanding_q + 1'b1;
    else if (!xfer && resp) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      addr_q        <= RESET_PC;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (flush) begin
        // Everything still in flight, including a grant taken this cycle, is stale.
        discard_q <= outstanding_d;
        occ_q     <= '0;
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
        pcq_rd_q  <= '0;
        pcq_wr_q  <= '0;
        addr_q    <= branch_target_in;
      end else begin
        if (drop) discard_q <= discard_q - 1'b1;
        if (xfer) begin
          addr_q   <= addr_q + XLEN'(4);
          pcq_wr_q <= pcq_wr_q + 1'b1;
        end
        if (resp && !drop) pcq_rd_q <= pcq_rd_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      occ_q <= occ_q + 1'b1;
        else if (!push && pop) occ_q <= occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge req) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem.instr_rdata_in;
      pc_mem[wr_ptr_q]    <= pcq_mem[pcq_rd_q];
    end
    if (xfer) pcq_mem[pcq_wr_q] <= addr_q;
  end

  rvalid_with_outstanding: assert property (
    @(posedge req) disable iff (!reset) mem.instr_rvalid_in |-> (outstanding_q != '0)
  );
endmodule
